// File: rtl/tx_serial_arbitro_if.sv
// Bus between the four requesters, the round-robin arbiter and the 7E1 transmitter.
// The arbiter side uses 'master'; requesters/transmitter models use 'slave'.
interface tx_serial_arbitro_if;
   logic [3:0]  req;
   logic [27:0] dados;
   logic [3:0]  ack;
   logic [3:0]  concluido;
   logic        partida;
   logic [6:0]  dados_ascii;
   logic        pronto;

   modport master (
      input  req, dados, pronto,
      output ack, concluido, partida, dados_ascii
   );

   modport slave (
      output req, dados, pronto,
      input  ack, concluido, partida, dados_ascii
   );
endinterface

// File: rtl/tx_serial_arbitro.sv
// Round-robin arbiter sharing one tx_serial_7E1 among four requesters,
// with a watchdog that aborts a frame whose 'pronto' never arrives.
module tx_serial_arbitro #(
   parameter int TIMEOUT = 5000,
   parameter int TW      = 13
) (
   input  logic                clock,
   input  logic                reset,
   tx_serial_arbitro_if.master bus,
   output logic                ocupado,
   output logic                erro,
   output logic [1:0]          db_grant,
   output logic [3:0]          db_estado
);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      START = 4'd1,
      WAIT  = 4'd2,
      DONE  = 4'd3,
      ABORT = 4'd4
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    grant_q, grant_d;
   logic [6:0]    char_q, char_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          erro_q, erro_d;
   logic [1:0]    winner;
   logic [1:0]    scan_idx;
   logic [6:0]    winner_char;

   // Scanning from ptr+3 down to ptr leaves the request closest to ptr as winner.
   always_comb begin
      winner   = ptr_q;
      scan_idx = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         scan_idx = ptr_q + 2'(i);
         if (bus.req[scan_idx]) begin
            winner = scan_idx;
         end
      end
   end

   always_comb begin
      case (winner)
         2'd0:    winner_char = bus.dados[6:0];
         2'd1:    winner_char = bus.dados[13:7];
         2'd2:    winner_char = bus.dados[20:14];
         default: winner_char = bus.dados[27:21];
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         grant_q <= 2'd0;
         char_q  <= 7'd0;
         cnt_q   <= '0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         char_q  <= char_d;
         cnt_q   <= cnt_d;
         erro_q  <= erro_d;
      end
   end

   // A pronto seen in the terminal-count cycle takes priority over the abort.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      char_d  = char_q;
      cnt_d   = cnt_q;
      erro_d  = erro_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               grant_d = winner;
               char_d  = winner_char;
               state_d = START;
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (bus.pronto) begin
               state_d = DONE;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               state_d = ABORT;
            end
         end
         DONE: begin
            ptr_d   = grant_q + 2'd1;
            state_d = IDLE;
         end
         ABORT: begin
            erro_d  = 1'b1;
            ptr_d   = grant_q + 2'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.partida     = (state_q == START);
   assign bus.ack         = (state_q == START) ? (4'b0001 << grant_q) : 4'b0000;
   assign bus.concluido   = (state_q == DONE)  ? (4'b0001 << grant_q) : 4'b0000;
   assign bus.dados_ascii = char_q;
   assign ocupado         = (state_q != IDLE);
   assign erro            = erro_q;
   assign db_grant        = grant_q;
   assign db_estado       = state_q;

endmodule
